// File: rtl/hwag_ssram_pkg.sv
// ---------------------------------------------------------------------------
// hwag_ssram_pkg
// Shared types and constants for the hwag configuration/status SSRAM
// scheduler: FSM state encoding, arbitration winner encoding, the boot
// configuration entry layout and the well-known hwag register addresses.
// ---------------------------------------------------------------------------
package hwag_ssram_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RD_WAIT = 2'd2
  } sched_state_t;

  typedef enum logic {
    WIN_POLL = 1'b0,
    WIN_HOST = 1'b1
  } winner_t;

  // Number of boot configuration entries and the index width that walks them
  // (one spare code past the last entry marks "table finished").
  localparam int unsigned INIT_LEN  = 12;
  localparam int unsigned ROM_IDX_W = 4;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } cfg_entry_t;

  localparam logic [7:0] HWACR0  = 8'd63;
  localparam logic [7:0] HWATHVL = 8'd70;

endpackage

// File: rtl/hwag_ssram_sched_rom.sv
// ---------------------------------------------------------------------------
// hwag_cfg_rom
// Combinational boot configuration table: index -> {address, data}.
// Entries are replayed into hwag in index order after reset.
// Ports:
//   idx   in  ROM_IDX_W  table index (codes >= INIT_LEN return zero)
//   entry out cfg_entry_t  address/data pair for that index
// ---------------------------------------------------------------------------
module hwag_cfg_rom
  import hwag_ssram_pkg::*;
(
  input  logic [ROM_IDX_W-1:0] idx,
  output cfg_entry_t           entry
);

  always_comb begin
    entry = '{addr: 8'd0, data: 16'd0};
    case (idx)
      4'd0:  entry = '{addr: 8'd0,    data: 16'd128};   // capture limit low
      4'd1:  entry = '{addr: 8'd1,    data: 16'd0};
      4'd2:  entry = '{addr: 8'd2,    data: 16'd65535}; // capture limit high
      4'd3:  entry = '{addr: 8'd3,    data: 16'd0};
      4'd4:  entry = '{addr: 8'd4,    data: 16'd57};    // tooth count
      4'd5:  entry = '{addr: 8'd5,    data: 16'd4};
      4'd6:  entry = '{addr: 8'd6,    data: 16'd3839};
      4'd7:  entry = '{addr: HWACR0,  data: 16'd7};
      4'd8:  entry = '{addr: 8'd65,   data: 16'd2};     // interrupt enables
      4'd9:  entry = '{addr: HWATHVL, data: 16'd2};
      4'd10: entry = '{addr: 8'd127,  data: 16'd1024};  // ignition angles
      4'd11: entry = '{addr: 8'd129,  data: 16'd3830};
      default: entry = '{addr: 8'd0, data: 16'd0};
    endcase
  end

endmodule

// File: rtl/hwag_ssram_sched.sv
// ---------------------------------------------------------------------------
// hwag_ssram_sched
// Owns the hwag configuration/status SSRAM port. After reset it replays the
// boot configuration table, then arbitrates single-word accesses between the
// host requester and a periodic status poller (round-robin, one command per
// cycle). Reads hold the port for READ_LAT cycles after the strobe.
// Ports:
//   clk, rst (async, active-low)
//   host_req/we/addr/wdata  host command, held until host_gnt
//   host_gnt                one-cycle pulse when the host command is issued
//   host_rvalid/rdata       host read return (rdata held until next read)
//   poll_rvalid/addr/rdata  one pulse per polled status word
//   poll_ovr, poll_ovr_clr  sticky poll overrun flag and its clear
//   init_done               boot table fully written
//   ssram_*                 hwag SSRAM port (data_oe mirrors ssram_we)
// ---------------------------------------------------------------------------
module hwag_ssram_sched #(
  parameter int unsigned POLL_PERIOD = 1000,
  parameter logic [7:0]  POLL_BASE   = 8'd64,
  parameter int unsigned POLL_LEN    = 4,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [15:0] host_rdata,
  output logic        poll_rvalid,
  output logic [7:0]  poll_addr,
  output logic [15:0] poll_rdata,
  output logic        poll_ovr,
  input  logic        poll_ovr_clr,
  output logic        init_done,
  output logic        ssram_we,
  output logic        ssram_re,
  output logic [7:0]  ssram_addr,
  output logic [15:0] ssram_data_o,
  output logic        ssram_data_oe,
  input  logic [15:0] ssram_data_i
);

  import hwag_ssram_pkg::*;

  localparam int unsigned TMR_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  sched_state_t         state;
  winner_t              last_winner;
  logic [ROM_IDX_W-1:0] rom_idx;
  cfg_entry_t           rom_entry;
  logic [TMR_W-1:0]     poll_tmr;
  logic                 poll_pend;
  logic [3:0]           poll_idx;
  logic [1:0]           rd_cnt;
  logic                 rd_host;
  logic                 host_ok;
  logic                 pick_host;
  logic                 tmr_wrap;

  hwag_cfg_rom u_rom (
    .idx   (rom_idx),
    .entry (rom_entry)
  );

  // host_gnt is registered, so during the grant cycle the requester still
  // shows the request it just had accepted; masking it prevents a re-issue.
  assign host_ok   = host_req && !host_gnt;
  assign pick_host = host_ok && (!poll_pend || (last_winner == WIN_POLL));
  assign tmr_wrap  = init_done && (poll_tmr == TMR_W'(POLL_PERIOD - 1));

  assign ssram_data_oe = ssram_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_INIT;
      last_winner  <= WIN_POLL;
      rom_idx      <= '0;
      init_done    <= 1'b0;
      poll_pend    <= 1'b0;
      poll_idx     <= '0;
      rd_cnt       <= '0;
      rd_host      <= 1'b0;
      ssram_we     <= 1'b0;
      ssram_re     <= 1'b0;
      ssram_addr   <= '0;
      ssram_data_o <= '0;
      host_gnt     <= 1'b0;
      host_rvalid  <= 1'b0;
      host_rdata   <= '0;
      poll_rvalid  <= 1'b0;
      poll_addr    <= '0;
      poll_rdata   <= '0;
    end else begin
      ssram_we    <= 1'b0;
      ssram_re    <= 1'b0;
      host_gnt    <= 1'b0;
      host_rvalid <= 1'b0;
      poll_rvalid <= 1'b0;
      case (state)
        ST_INIT: begin
          if (rom_idx == ROM_IDX_W'(INIT_LEN)) begin
            init_done <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            ssram_we     <= 1'b1;
            ssram_addr   <= rom_entry.addr;
            ssram_data_o <= rom_entry.data;
            rom_idx      <= rom_idx + ROM_IDX_W'(1);
          end
        end
        ST_IDLE: begin
          if (pick_host) begin
            host_gnt    <= 1'b1;
            last_winner <= WIN_HOST;
            ssram_addr  <= host_addr;
            if (host_we) begin
              ssram_we     <= 1'b1;
              ssram_data_o <= host_wdata;
            end else begin
              ssram_re <= 1'b1;
              rd_host  <= 1'b1;
              rd_cnt   <= '0;
              state    <= ST_RD_WAIT;
            end
          end else if (poll_pend) begin
            last_winner <= WIN_POLL;
            ssram_re    <= 1'b1;
            ssram_addr  <= POLL_BASE + {4'd0, poll_idx};
            rd_host     <= 1'b0;
            rd_cnt      <= '0;
            state       <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          // ssram_addr is untouched while waiting, so it still names the word.
          if (rd_cnt == 2'(READ_LAT)) begin
            state <= ST_IDLE;
            if (rd_host) begin
              host_rvalid <= 1'b1;
              host_rdata  <= ssram_data_i;
            end else begin
              poll_rvalid <= 1'b1;
              poll_addr   <= ssram_addr;
              poll_rdata  <= ssram_data_i;
              poll_idx    <= poll_idx + 4'd1;
              if (poll_idx == 4'(POLL_LEN - 1)) poll_pend <= 1'b0;
            end
          end else begin
            rd_cnt <= rd_cnt + 2'd1;
          end
        end
        default: state <= ST_INIT;
      endcase
      // A timer wrap restarts the burst and overrides a same-cycle capture.
      if (tmr_wrap) begin
        poll_pend <= 1'b1;
        poll_idx  <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      poll_tmr <= '0;
      poll_ovr <= 1'b0;
    end else begin
      if (!init_done || tmr_wrap) poll_tmr <= '0;
      else                        poll_tmr <= poll_tmr + TMR_W'(1);
      if (tmr_wrap && poll_pend) poll_ovr <= 1'b1;
      else if (poll_ovr_clr)     poll_ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hwag_ssram_sched.sv
module tb_hwag_ssram_sched;
  import hwag_ssram_pkg::*;

  localparam int unsigned PER = 50;
  localparam int unsigned LEN = 4;
  localparam int unsigned LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_gnt, host_rvalid, poll_rvalid, poll_ovr, init_done;
  logic [15:0] host_rdata, poll_rdata, ssram_data_o, ssram_data_i;
  logic [7:0]  poll_addr, ssram_addr;
  logic        ssram_we, ssram_re, ssram_data_oe;
  logic        poll_ovr_clr = 1'b0;

  logic        o_host_gnt, o_host_rvalid, o_poll_rvalid, o_poll_ovr, o_init_done;
  logic [15:0] o_host_rdata, o_poll_rdata, o_ssram_data_o;
  logic [7:0]  o_poll_addr, o_ssram_addr;
  logic        o_ssram_we, o_ssram_re, o_ssram_data_oe;
  logic        o_ovr_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  hwag_ssram_sched #(.POLL_PERIOD(PER), .POLL_BASE(8'd64), .POLL_LEN(LEN), .READ_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .poll_rvalid(poll_rvalid), .poll_addr(poll_addr),
    .poll_rdata(poll_rdata), .poll_ovr(poll_ovr), .poll_ovr_clr(poll_ovr_clr),
    .init_done(init_done), .ssram_we(ssram_we), .ssram_re(ssram_re),
    .ssram_addr(ssram_addr), .ssram_data_o(ssram_data_o), .ssram_data_oe(ssram_data_oe),
    .ssram_data_i(ssram_data_i)
  );

  // Second instance whose poll burst can never finish inside one period.
  hwag_ssram_sched #(.POLL_PERIOD(8), .POLL_BASE(8'd64), .POLL_LEN(4), .READ_LAT(3)) u_ovr (
    .clk(clk), .rst(rst), .host_req(1'b0), .host_we(1'b0), .host_addr(8'd0),
    .host_wdata(16'd0), .host_gnt(o_host_gnt), .host_rvalid(o_host_rvalid),
    .host_rdata(o_host_rdata), .poll_rvalid(o_poll_rvalid), .poll_addr(o_poll_addr),
    .poll_rdata(o_poll_rdata), .poll_ovr(o_poll_ovr), .poll_ovr_clr(o_ovr_clr),
    .init_done(o_init_done), .ssram_we(o_ssram_we), .ssram_re(o_ssram_re),
    .ssram_addr(o_ssram_addr), .ssram_data_o(o_ssram_data_o), .ssram_data_oe(o_ssram_data_oe),
    .ssram_data_i(16'h1234)
  );

  // hwag SSRAM model: unwritten words read as {A5, addr}; read data appears
  // the cycle after the strobe (READ_LAT = 1).
  logic [15:0]  mem [256];
  logic [255:0] wr_vld = '0;
  logic         re_d = 1'b0;
  logic [7:0]   addr_d = '0;
  always @(posedge clk) begin
    if (ssram_we) begin
      mem[ssram_addr]    <= ssram_data_o;
      wr_vld[ssram_addr] <= 1'b1;
    end
    re_d   <= ssram_re;
    addr_d <= ssram_addr;
  end
  assign ssram_data_i = !re_d ? 16'hDEAD : (wr_vld[addr_d] ? mem[addr_d] : {8'hA5, addr_d});

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("we_re_exclusive", 32'(ssram_we & ssram_re), 32'd0);
      check("oe_follows_we", 32'(ssram_data_oe), 32'(ssram_we));
    end
  end

  typedef struct { logic [7:0] addr; logic [15:0] data; } init_vec_t;
  typedef struct { logic we; logic [7:0] addr; logic [15:0] wdata; logic [15:0] exp_rdata; } host_vec_t;
  init_vec_t   init_tbl [12];
  host_vec_t   host_tbl [7];
  logic [15:0] exp_poll [4];

  task automatic check_init_seq(input string tag, input int drop_at);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == drop_at) host_req = 1'b0;
      check({tag, "_we"}, 32'(ssram_we), 32'd1);
      check({tag, "_addr"}, 32'(ssram_addr), 32'(init_tbl[i].addr));
      check({tag, "_data"}, 32'(ssram_data_o), 32'(init_tbl[i].data));
      check({tag, "_gnt"}, 32'(host_gnt), 32'd0);
      check({tag, "_rvalid"}, 32'(host_rvalid), 32'd0);
      check({tag, "_done_early"}, 32'(init_done), 32'd0);
    end
    @(negedge clk);
    check({tag, "_done"}, 32'(init_done), 32'd1);
    check({tag, "_we_after"}, 32'(ssram_we), 32'd0);
    check({tag, "_gnt_after"}, 32'(host_gnt), 32'd0);
  endtask

  task automatic wait_gnt(output bit ok);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!host_gnt && n < 200);
    ok = host_gnt;
  endtask

  task automatic host_op(input host_vec_t v);
    bit ok;
    int lat;
    host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
    wait_gnt(ok);
    check("hop_gnt_seen", 32'(ok), 32'd1);
    if (ok) begin
      host_req = 1'b0;
      check("hop_addr", 32'(ssram_addr), 32'(v.addr));
      check("hop_we", 32'(ssram_we), 32'(v.we));
      check("hop_re", 32'(ssram_re), 32'(!v.we));
      if (v.we) begin
        check("hop_wdata", 32'(ssram_data_o), 32'(v.wdata));
      end else begin
        lat = 0;
        do begin @(negedge clk); lat++; end while (!host_rvalid && lat < 20);
        check("hop_rd_latency", 32'(lat), 32'(LAT + 1));
        check("hop_rdata", 32'(host_rdata), 32'(v.exp_rdata));
      end
    end
  endtask

  task automatic wait_poll64(output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (poll_rvalid && poll_addr == 8'd64) begin ok = 1'b1; t = cyc_cnt; end
    end
  endtask

  initial begin
    bit ok, seen;
    int t_b, t_c, n, hosts_between, n_poll, n_host;
    bit seen_poll;

    init_tbl[0]  = '{8'd0,   16'd128};   init_tbl[1]  = '{8'd1,   16'd0};
    init_tbl[2]  = '{8'd2,   16'd65535}; init_tbl[3]  = '{8'd3,   16'd0};
    init_tbl[4]  = '{8'd4,   16'd57};    init_tbl[5]  = '{8'd5,   16'd4};
    init_tbl[6]  = '{8'd6,   16'd3839};  init_tbl[7]  = '{8'd63,  16'd7};
    init_tbl[8]  = '{8'd65,  16'd2};     init_tbl[9]  = '{8'd70,  16'd2};
    init_tbl[10] = '{8'd127, 16'd1024};  init_tbl[11] = '{8'd129, 16'd3830};

    host_tbl[0] = '{1'b0, 8'd63,  16'h0000, 16'h0007};
    host_tbl[1] = '{1'b0, 8'd129, 16'h0000, 16'h0EF6};
    host_tbl[2] = '{1'b1, 8'd100, 16'hBEEF, 16'h0000};
    host_tbl[3] = '{1'b0, 8'd100, 16'h0000, 16'hBEEF};
    host_tbl[4] = '{1'b0, 8'd2,   16'h0000, 16'hFFFF};
    host_tbl[5] = '{1'b0, 8'd200, 16'h0000, 16'hA5C8};
    host_tbl[6] = '{1'b0, 8'd70,  16'h0000, 16'h0005};

    exp_poll[0] = 16'hA540; exp_poll[1] = 16'h0002;
    exp_poll[2] = 16'hA542; exp_poll[3] = 16'hA543;

    // Reset; host write to HWATHVL held throughout init.
    host_req = 1'b1; host_we = 1'b1; host_addr = HWATHVL; host_wdata = 16'd5;
    repeat (3) @(negedge clk);
    check("rst_we", 32'(ssram_we), 32'd0);
    check("rst_re", 32'(ssram_re), 32'd0);
    check("rst_gnt", 32'(host_gnt), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    check("rst_ovr", 32'(poll_ovr), 32'd0);
    check("rst_addr", 32'(ssram_addr), 32'd0);
    check("rst_pvalid", 32'(poll_rvalid), 32'd0);
    rst = 1'b1;
    check_init_seq("init", -1);

    // Held host write is granted the cycle after init_done rises.
    @(negedge clk);
    check("hw_gnt", 32'(host_gnt), 32'd1);
    check("hw_we", 32'(ssram_we), 32'd1);
    check("hw_addr", 32'(ssram_addr), 32'd70);
    check("hw_data", 32'(ssram_data_o), 32'd5);
    check("hw_oe", 32'(ssram_data_oe), 32'd1);
    host_req = 1'b0;

    for (int i = 0; i < 7; i++) host_op(host_tbl[i]);

    // Periodic poll bursts with no host traffic.
    wait_poll64(t_b, ok);
    check("poll_first_seen", 32'(ok), 32'd1);
    wait_poll64(t_b, ok);
    check("poll_b_seen", 32'(ok), 32'd1);
    check("poll_w0_data", 32'(poll_rdata), 32'(exp_poll[0]));
    for (int w = 1; w < 4; w++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!poll_rvalid && n < 20);
      check("poll_w_seen", 32'(poll_rvalid), 32'd1);
      check("poll_w_addr", 32'(poll_addr), 32'(64 + w));
      check("poll_w_data", 32'(poll_rdata), 32'(exp_poll[w]));
    end
    wait_poll64(t_c, ok);
    check("poll_c_seen", 32'(ok), 32'd1);
    check("poll_period", 32'(t_c - t_b), 32'(PER));

    // Continuous host reads across poll bursts: grants must alternate.
    host_req = 1'b1; host_we = 1'b0; host_addr = HWACR0;
    hosts_between = 0; n_poll = 0; n_host = 0; seen_poll = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (ssram_re) begin
        if (host_gnt) begin
          hosts_between++; n_host++;
        end else begin
          n_poll++;
          if (seen_poll && ssram_addr != 8'd64) check("rr_alternate", 32'(hosts_between), 32'd1);
          seen_poll = 1'b1; hosts_between = 0;
        end
      end
      if (host_rvalid) check("rr_hrdata", 32'(host_rdata), 32'd7);
    end
    host_req = 1'b0;
    check("rr_polls_seen", 32'(n_poll >= 4), 32'd1);
    check("rr_hosts_seen", 32'(n_host >= 8), 32'd1);
    check("main_no_ovr", 32'(poll_ovr), 32'd0);

    // Overrun instance: flag set, cleared by a pulse, re-set at next wrap.
    check("ovr_set", 32'(o_poll_ovr), 32'd1);
    o_ovr_clr = 1'b1; @(negedge clk); o_ovr_clr = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_poll_ovr && n < 20);
    check("ovr_rise_seen", 32'(o_poll_ovr), 32'd1);
    o_ovr_clr = 1'b1; @(negedge clk); o_ovr_clr = 1'b0;
    check("ovr_cleared", 32'(o_poll_ovr), 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_poll_ovr && n < 20);
    check("ovr_reset", 32'(o_poll_ovr), 32'd1);
    check("ovr_reset_within_period", 32'(n <= 8), 32'd1);
    o_ovr_clr = 1'b1; seen = 1'b0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (o_poll_ovr) seen = 1'b1; end
    o_ovr_clr = 1'b0;
    check("ovr_set_beats_clr", 32'(seen), 32'd1);

    // Reset during a host read: no rvalid, full init replay.
    repeat (5) @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = HWACR0;
    wait_gnt(ok);
    check("mr_gnt_seen", 32'(ok), 32'd1);
    host_req = 1'b0;
    rst = 1'b0;
    #1;
    check("mr_re_cleared", 32'(ssram_re), 32'd0);
    check("mr_done_cleared", 32'(init_done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mr_no_rvalid", 32'(host_rvalid), 32'd0);
    end
    // Host write request withdrawn during init must never be granted.
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'd5; host_wdata = 16'hFFFF;
    rst = 1'b1;
    check_init_seq("reinit", 3);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("withdrawn_no_gnt", 32'(host_gnt), 32'd0);
      check("withdrawn_no_we", 32'(ssram_we), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
